// File: rtl/apb_mport_ctrl.sv
// Multi-port APB3 master sequencer: one synchronised command becomes one APB transfer on a chosen port.
// Reports read data, a sticky done flag, an error code and dropped commands.
module apb_mport_ctrl #(
  parameter int NPORT   = 2,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255,
  localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                apb_clk,
  input  logic                apb_rst_n,
  input  logic                cmd_en,
  input  logic                cmd_wr,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [DW-1:0]       cmd_wdata,
  input  logic [PW-1:0]       cmd_port,
  output logic [NPORT-1:0]    m_psel,
  output logic [NPORT-1:0]    m_penable,
  output logic [NPORT-1:0]    m_pwrite,
  output logic [NPORT*AW-1:0] m_paddr,
  output logic [NPORT*DW-1:0] m_pwdata,
  input  logic [NPORT-1:0]    m_pready,
  input  logic [NPORT*DW-1:0] m_prdata,
  input  logic [NPORT-1:0]    m_pslverr,
  output logic                apb_busy,
  output logic                apb_done,
  output logic [1:0]          apb_err,
  output logic [DW-1:0]       apb_rd_data,
  output logic                apb_drop
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_END} state_t;

  state_t state, state_nxt;

  logic          en_d1, en_d2, en_d3;
  logic          wr_s1, wr_s2;
  logic [AW-1:0] addr_s1, addr_s2;
  logic [DW-1:0] wdata_s1, wdata_s2;
  logic [PW-1:0] port_s1, port_s2;
  logic          cmd_pos;
  logic          port_bad;

  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [PW-1:0] port_q;
  logic [CW-1:0] cnt;
  logic [1:0]    err_q, err_nxt;

  logic          capture, cnt_clr, cnt_inc, load_rd, drop_nxt;
  logic          sel_ready, sel_err;
  logic [DW-1:0] sel_rdata;

  logic          eff_wr;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_wdata;
  logic [PW-1:0] eff_port;
  logic [NPORT-1:0]    psel_nxt, penable_nxt, pwrite_nxt;
  logic [NPORT*AW-1:0] paddr_nxt;
  logic [NPORT*DW-1:0] pwdata_nxt;

  // Command fields only need two stages; the strobe gets a third for edge detection.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      en_d1    <= 1'b0;
      en_d2    <= 1'b0;
      en_d3    <= 1'b0;
      wr_s1    <= 1'b0;
      wr_s2    <= 1'b0;
      addr_s1  <= '0;
      addr_s2  <= '0;
      wdata_s1 <= '0;
      wdata_s2 <= '0;
      port_s1  <= '0;
      port_s2  <= '0;
    end else begin
      en_d1    <= cmd_en;
      en_d2    <= en_d1;
      en_d3    <= en_d2;
      wr_s1    <= cmd_wr;
      wr_s2    <= wr_s1;
      addr_s1  <= cmd_addr;
      addr_s2  <= addr_s1;
      wdata_s1 <= cmd_wdata;
      wdata_s2 <= wdata_s1;
      port_s1  <= cmd_port;
      port_s2  <= port_s1;
    end
  end

  assign cmd_pos = en_d2 & ~en_d3;

  // An out-of-range index only exists when NPORT is not a power of two.
  generate
    if ((1 << PW) > NPORT) begin : g_port_chk
      assign port_bad = (int'(port_s2) >= NPORT);
    end else begin : g_port_ok
      assign port_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (port_q == PW'(k)) begin
        sel_ready = m_pready[k];
        sel_err   = m_pslverr[k];
        sel_rdata = m_prdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load_rd   = 1'b0;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (cmd_pos) begin
          capture = 1'b1;
          if (port_bad) begin
            state_nxt = S_END;
            err_nxt   = 2'd3;
          end else begin
            state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_nxt = S_ACCESS;
        cnt_clr   = 1'b1;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          state_nxt = S_END;
          err_nxt   = {1'b0, sel_err};
          load_rd   = ~wr_q;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = S_END;
          err_nxt   = 2'd2;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    drop_nxt = cmd_pos && (state != S_IDLE);
  end

  // Bus outputs are computed from the next state so they change on the same edge as the FSM.
  always_comb begin
    eff_wr      = capture ? wr_s2    : wr_q;
    eff_addr    = capture ? addr_s2  : addr_q;
    eff_wdata   = capture ? wdata_s2 : wdata_q;
    eff_port    = capture ? port_s2  : port_q;
    psel_nxt    = '0;
    penable_nxt = '0;
    pwrite_nxt  = '0;
    paddr_nxt   = '0;
    pwdata_nxt  = '0;
    if (state_nxt == S_SETUP || state_nxt == S_ACCESS) begin
      for (int k = 0; k < NPORT; k++) begin
        if (eff_port == PW'(k)) begin
          psel_nxt[k]             = 1'b1;
          penable_nxt[k]          = (state_nxt == S_ACCESS);
          pwrite_nxt[k]           = eff_wr;
          paddr_nxt[k*AW +: AW]   = eff_addr;
          pwdata_nxt[k*DW +: DW]  = eff_wdata;
        end
      end
    end
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      port_q      <= '0;
      cnt         <= '0;
      err_q       <= 2'd0;
      apb_err     <= 2'd0;
      apb_done    <= 1'b0;
      apb_rd_data <= '0;
      apb_drop    <= 1'b0;
      m_psel      <= '0;
      m_penable   <= '0;
      m_pwrite    <= '0;
      m_paddr     <= '0;
      m_pwdata    <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (capture) begin
        wr_q     <= wr_s2;
        addr_q   <= addr_s2;
        wdata_q  <= wdata_s2;
        port_q   <= port_s2;
        apb_done <= 1'b0;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
      if (load_rd) begin
        apb_rd_data <= sel_rdata;
      end
      if (state == S_END) begin
        apb_done <= 1'b1;
        apb_err  <= err_q;
      end
      apb_drop  <= drop_nxt;
      m_psel    <= psel_nxt;
      m_penable <= penable_nxt;
      m_pwrite  <= pwrite_nxt;
      m_paddr   <= paddr_nxt;
      m_pwdata  <= pwdata_nxt;
    end
  end

  assign apb_busy = (state != S_IDLE);

endmodule

// File: doc/apb_mport_ctrl.md
# apb_mport_ctrl

Parametrised, multi-port APB master sequencer for DDR controller/PHY register access. It accepts one asynchronously sourced command (level strobe plus address, data, direction and port index) and runs a single APB3 transfer on one of NPORT slave ports. It returns a read-data register, a sticky done flag and an error code. It adds per-transfer timeout, PSLVERR capture, invalid-port rejection and dropped-command reporting.

## Interface
Parameters:
- NPORT, 2: number of APB slave ports (1..16).
- AW, 8: APB address width.
- DW, 16: APB data width.
- TIMEOUT, 255: maximum ACCESS-phase cycles waiting for PREADY (≥1). The counter width is clog2(TIMEOUT+1).
- PW: derived, max(1, clog2(NPORT)).

Ports:
- apb_clk  in  1  clock; all logic is on its rising edge.
- apb_rst_n  in  1  reset, asynchronous, active-low.
- cmd_en  in  1  command strobe from another domain; a rising edge requests a transfer.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  target address.
- cmd_wdata  in  DW  write data.
- cmd_port  in  PW  target port index.
- m_psel  out  NPORT  per-port PSEL.
- m_penable  out  NPORT  per-port PENABLE.
- m_pwrite  out  NPORT  per-port PWRITE.
- m_paddr  out  NPORT*AW  per-port PADDR; port k occupies bits [k*AW +: AW].
- m_pwdata  out  NPORT*DW  per-port PWDATA, packed the same way.
- m_pready  in  NPORT  per-port PREADY.
- m_prdata  in  NPORT*DW  per-port PRDATA.
- m_pslverr  in  NPORT  per-port PSLVERR.
- apb_busy  out  1  high while a command is in progress (state ≠ IDLE).
- apb_done  out  1  sticky completion flag.
- apb_err  out  2  completion status: 0 ok, 1 slave error, 2 timeout, 3 bad port.
- apb_rd_data  out  DW  last read data.
- apb_drop  out  1  one-cycle pulse when a command edge is ignored.

## Operation
- Synchronisation:
  - cmd_en passes through a 3-flop chain (d1, d2, d3); cmd_pos = d2 & ~d3.
  - cmd_wr, cmd_addr, cmd_wdata and cmd_port each pass through a 2-flop chain and are sampled in the cycle cmd_pos is high.
  - The source must hold all command fields stable from at least 1 cycle before the cmd_en rise until apb_done is set.
- FSM states: IDLE, SETUP, ACCESS, END.
  - IDLE: on cmd_pos, capture the command. Go to END with err=3 if port ≥ NPORT; otherwise go to SETUP.
  - SETUP: lasts 1 cycle, then go to ACCESS. Clear the timeout counter.
  - ACCESS: if m_pready[port]=1, go to END. err is 1 if m_pslverr[port]=1, else 0. Otherwise increment the counter; when the counter equals TIMEOUT-1 with no PREADY, go to END with err=2.
  - END: lasts 1 cycle, then go to IDLE.
- Bus outputs are registered and updated on the same edge as the state change:
  - In SETUP: psel=1, penable=0.
  - In ACCESS: psel=1, penable=1.
  - pwrite, paddr and pwdata hold the captured values in both SETUP and ACCESS.
  - Only the selected port's fields are non-zero. All port fields are 0 in IDLE and END.
- apb_rd_data:
  - Loaded from m_prdata[port] on the ACCESS cycle where PREADY=1 for a read, including when PSLVERR=1.
  - Not changed by writes, timeouts or bad-port commands.
- apb_done and apb_err:
  - apb_done is set on the cycle after END (END→IDLE edge), together with apb_err.
  - apb_done is cleared when the next command is accepted in IDLE. apb_err keeps its value until the next completion.
- A cmd_pos seen while state ≠ IDLE is discarded, and apb_drop pulses for 1 cycle.

## Timing
- Reset values: all m_* outputs 0, apb_busy 0, apb_done 0, apb_err 0, apb_rd_data 0, apb_drop 0, state IDLE, all synchroniser flops 0.
- Edge numbering: cmd_en rises before edge E0. cmd_pos is high after E1. psel rises at E2 (SETUP) and penable rises at E3 (ACCESS).
- With zero wait states: PREADY is sampled at E4, END occupies E4–E5, and apb_done rises at E5.
- Each wait state adds 1 cycle. A timeout ends ACCESS after exactly TIMEOUT cycles of penable=1.
- Bad port: END occurs at E2 and apb_done rises at E3. No psel is asserted on any port.
- Minimum spacing between two accepted commands: cmd_en must be low for ≥2 apb_clk cycles between rising edges.
- Asynchronous reset in any state immediately forces all outputs to their reset values. A transfer in flight at reset is abandoned, and its apb_done is never set.

## Test plan
- NPORT=2, write addr 0x34 data 0xBEEF to port 0 with a zero-wait slave:
  - psel[0] high for 2 cycles and penable[0] high for 1 cycle.
  - port 1 outputs stay at 0 throughout.
  - apb_done=1 and apb_err=0 at E5.
- Read addr 0x10 from port 1 with 3 wait states, prdata=0x5A5A:
  - penable[1] high for 4 cycles.
  - apb_rd_data=0x5A5A and apb_err=0.
- TIMEOUT=8 and the slave never asserts PREADY:
  - penable high for exactly 8 cycles.
  - apb_err=2, apb_done=1, apb_rd_data unchanged.
- Read with PSLVERR=1 and prdata=0x1234 on the PREADY cycle:
  - apb_err=1 and apb_rd_data=0x1234.
- NPORT=3 with cmd_port=3:
  - no psel activity on any port.
  - apb_err=3 and apb_done rises at E3.
- Mid-transfer cases:
  - A second cmd_en edge during ACCESS pulses apb_drop once and the first transfer completes normally.
  - Asserting apb_rst_n=0 during ACCESS clears all outputs immediately, and the next command runs normally.
